// File: rtl/ptp_up_pkg.sv
// Shared types and defaults for the ha1588 register-bus initiator.
// Holds the opcode enum, the sequencer state encoding, the per-access descriptor,
// and the default register map and control words of the ha1588 RTC.
package ptp_up_pkg;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_SET_TIME = 2'd1,
        OP_SET_PER  = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    // Sequencer states, kept as plain constants so the encoding is visible in waves.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STROBE = 2'd1;
    localparam state_t ST_GAP    = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    localparam logic [7:0]  DEF_ADDR_CTRL      = 8'h00;
    localparam logic [7:0]  DEF_ADDR_SEC       = 8'h10;
    localparam logic [7:0]  DEF_ADDR_NS        = 8'h14;
    localparam logic [7:0]  DEF_ADDR_PERIOD    = 8'h18;
    localparam logic [31:0] DEF_CTRL_SNAP      = 32'h1;
    localparam logic [31:0] DEF_CTRL_LOAD_TIME = 32'h2;
    localparam logic [31:0] DEF_CTRL_LOAD_PER  = 32'h4;

    // One register access: direction, address and write data.
    typedef struct packed {
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    // Number of bus accesses each opcode performs.
    function automatic logic [1:0] op_num_acc(input op_e op);
        case (op)
            OP_READ:     return 2'd3;
            OP_SET_TIME: return 2'd3;
            OP_SET_PER:  return 2'd2;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ptp_up_if.sv
// Command/response channel plus ha1588 register bus between a controller and ptp_up_master.
// master modport: the initiator's view (takes commands, drives the bus strobes).
// slave modport: the environment's view (issues commands, answers register reads).
interface ptp_up_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_sec;
    logic [31:0] cmd_ns;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_sec;
    logic [31:0] rsp_ns;
    logic        up_wr;
    logic        up_rd;
    logic [7:0]  up_addr;
    logic [31:0] up_data_wr;
    logic [31:0] up_data_rd;

    modport master (
        input  cmd_valid, cmd_op, cmd_sec, cmd_ns, up_data_rd,
        output cmd_ready, rsp_valid, rsp_err, rsp_sec, rsp_ns,
        output up_wr, up_rd, up_addr, up_data_wr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_sec, cmd_ns, up_data_rd,
        input  cmd_ready, rsp_valid, rsp_err, rsp_sec, rsp_ns,
        input  up_wr, up_rd, up_addr, up_data_wr
    );
endinterface

// File: rtl/ptp_up_access.sv
// Single register access engine: one-cycle strobe followed by a wait gap.
// Latency: strobe the cycle after start_i; done_o in the last gap cycle (1 after a write, RD_LAT after a read).
// Backpressure: none; start_i is only raised when idle or together with done_o.
// Ports: clk/rst; start_i + acc_i request; up_* register bus outputs, up_data_rd_i read data;
//        done_o pulse with rd_data_o valid in the same cycle.
module ptp_up_access
    import ptp_up_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  acc_t        acc_i,
    input  logic [31:0] up_data_rd_i,
    output logic        up_wr_o,
    output logic        up_rd_o,
    output logic [7:0]  up_addr_o,
    output logic [31:0] up_data_wr_o,
    output logic        done_o,
    output logic [31:0] rd_data_o
);

    // Extra gap cycles after the first one for a read.
    localparam logic [1:0] RD_WAIT = 2'(RD_LAT - 1);

    logic        wr_q;
    logic        rd_q;
    logic        is_rd_q;
    logic        gap_q;
    logic [1:0]  cnt_q;
    logic [7:0]  addr_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            is_rd_q <= 1'b0;
            gap_q   <= 1'b0;
            cnt_q   <= 2'd0;
            addr_q  <= 8'h00;
            data_q  <= 32'h0;
        end else begin
            // Strobes are single-cycle by construction.
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            if (start_i) begin
                wr_q    <= ~acc_i.rd;
                rd_q    <= acc_i.rd;
                is_rd_q <= acc_i.rd;
                addr_q  <= acc_i.addr;
                data_q  <= acc_i.rd ? 32'h0 : acc_i.data;
                gap_q   <= 1'b0;
            end else if (wr_q || rd_q) begin
                gap_q <= 1'b1;
                cnt_q <= is_rd_q ? RD_WAIT : 2'd0;
            end else if (gap_q) begin
                if (cnt_q == 2'd0) begin
                    gap_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
            end
        end
    end

    // Address and write data stay registered until the next start, so they
    // are stable across the whole gap.
    assign up_wr_o      = wr_q;
    assign up_rd_o      = rd_q;
    assign up_addr_o    = addr_q;
    assign up_data_wr_o = data_q;
    assign done_o       = gap_q && (cnt_q == 2'd0);
    assign rd_data_o    = up_data_rd_i;

endmodule

// File: rtl/ptp_up_master.sv
// ha1588 register-bus initiator: expands READ_TIME / SET_TIME / SET_PERIOD into fixed access sequences.
// Latency: rsp_valid 7 cycles after accept (SET_TIME), 5 (SET_PERIOD), 3+2*(RD_LAT+1) (READ_TIME), 1 (reserved).
// Backpressure: cmd_ready only in IDLE; one command in flight, next accept the cycle after the response.
// Ports: clk, rst (async active-low); bus = ptp_up_if.master carrying cmd_*, rsp_* and up_* signals.
module ptp_up_master
    import ptp_up_pkg::*;
#(
    parameter int          RD_LAT         = 1,
    parameter logic [7:0]  ADDR_CTRL      = DEF_ADDR_CTRL,
    parameter logic [7:0]  ADDR_SEC       = DEF_ADDR_SEC,
    parameter logic [7:0]  ADDR_NS        = DEF_ADDR_NS,
    parameter logic [7:0]  ADDR_PERIOD    = DEF_ADDR_PERIOD,
    parameter logic [31:0] CTRL_SNAP      = DEF_CTRL_SNAP,
    parameter logic [31:0] CTRL_LOAD_TIME = DEF_CTRL_LOAD_TIME,
    parameter logic [31:0] CTRL_LOAD_PER  = DEF_CTRL_LOAD_PER
) (
    input  logic     clk,
    input  logic     rst,
    ptp_up_if.master bus
);

    state_t      state_q, state_d;
    op_e         op_q;
    logic [31:0] sec_q;
    logic [31:0] ns_q;
    logic [1:0]  step_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_sec_q;
    logic [31:0] rsp_ns_q;
    logic [31:0] snap_sec_q;

    logic        accept;
    logic        acc_done;
    logic [31:0] acc_rdata;
    logic        acc_start;
    logic        last_step;
    logic        enter_resp;
    op_e         seq_op;
    logic [1:0]  seq_step;
    logic [31:0] seq_sec;
    logic [31:0] seq_ns;
    acc_t        acc;

    assign accept = bus.cmd_valid && ready_q;

    // The access to launch next: step 0 of the incoming command on accept,
    // otherwise the step after the one currently finishing.
    assign seq_op   = accept ? op_e'(bus.cmd_op) : op_q;
    assign seq_sec  = accept ? bus.cmd_sec : sec_q;
    assign seq_ns   = accept ? bus.cmd_ns  : ns_q;
    assign seq_step = accept ? 2'd0 : step_q + 2'd1;

    always_comb begin
        acc = '0;
        case (seq_op)
            OP_READ: begin
                case (seq_step)
                    2'd0:    acc = '{rd: 1'b0, addr: ADDR_CTRL, data: CTRL_SNAP};
                    2'd1:    acc = '{rd: 1'b1, addr: ADDR_SEC,  data: 32'h0};
                    default: acc = '{rd: 1'b1, addr: ADDR_NS,   data: 32'h0};
                endcase
            end
            OP_SET_TIME: begin
                case (seq_step)
                    2'd0:    acc = '{rd: 1'b0, addr: ADDR_SEC,  data: seq_sec};
                    2'd1:    acc = '{rd: 1'b0, addr: ADDR_NS,   data: seq_ns};
                    default: acc = '{rd: 1'b0, addr: ADDR_CTRL, data: CTRL_LOAD_TIME};
                endcase
            end
            OP_SET_PER: begin
                case (seq_step)
                    2'd0:    acc = '{rd: 1'b0, addr: ADDR_PERIOD, data: seq_ns};
                    default: acc = '{rd: 1'b0, addr: ADDR_CTRL,   data: CTRL_LOAD_PER};
                endcase
            end
            default: acc = '0;
        endcase
    end

    assign last_step = (step_q == op_num_acc(op_q) - 2'd1);
    assign acc_start = (accept && (op_e'(bus.cmd_op) != OP_RSVD)) || (acc_done && !last_step);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_e'(bus.cmd_op) == OP_RSVD) ? ST_RESP : ST_STROBE;
                end
            end
            ST_STROBE: state_d = ST_GAP;
            ST_GAP: begin
                if (acc_done) begin
                    state_d = last_step ? ST_RESP : ST_STROBE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RESP is a single cycle, so any cycle heading into RESP is an entry.
    assign enter_resp = (state_d == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            sec_q       <= 32'h0;
            ns_q        <= 32'h0;
            step_q      <= 2'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_sec_q   <= 32'h0;
            rsp_ns_q    <= 32'h0;
            snap_sec_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= enter_resp;

            if (accept) begin
                op_q   <= op_e'(bus.cmd_op);
                sec_q  <= bus.cmd_sec;
                ns_q   <= bus.cmd_ns;
                step_q <= 2'd0;
            end else if (acc_done && !last_step) begin
                step_q <= step_q + 2'd1;
            end

            // Seconds arrive one access before nanoseconds; park them so the
            // visible response only changes at RESP.
            if (acc_done && (op_q == OP_READ) && (step_q == 2'd1)) begin
                snap_sec_q <= acc_rdata;
            end

            if (enter_resp) begin
                // accept here can only mean the reserved opcode (no bus work).
                rsp_err_q <= accept;
                rsp_sec_q <= (!accept && op_q == OP_READ) ? snap_sec_q : 32'h0;
                rsp_ns_q  <= (!accept && op_q == OP_READ) ? acc_rdata  : 32'h0;
            end else begin
                rsp_err_q <= 1'b0;
            end
        end
    end

    ptp_up_access #(.RD_LAT(RD_LAT)) u_access (
        .clk          (clk),
        .rst          (rst),
        .start_i      (acc_start),
        .acc_i        (acc),
        .up_data_rd_i (bus.up_data_rd),
        .up_wr_o      (bus.up_wr),
        .up_rd_o      (bus.up_rd),
        .up_addr_o    (bus.up_addr),
        .up_data_wr_o (bus.up_data_wr),
        .done_o       (acc_done),
        .rd_data_o    (acc_rdata)
    );

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_sec   = rsp_sec_q;
    assign bus.rsp_ns    = rsp_ns_q;

endmodule

// File: tb/tb_ptp_up_master.sv
// Testbench for ptp_up_master: two instances (RD_LAT=1 and RD_LAT=3) sharing clock and reset,
// a register responder answering reads RD_LAT cycles after the strobe, and a reference model
// that derives the expected access list and timing from each opcode's register sequence.
module tb_ptp_up_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ptp_up_if if1 ();
    ptp_up_if if3 ();

    ptp_up_master #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    ptp_up_master #(.RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op    = 2'd0;
    logic [31:0] cmd_sec   = 32'h0;
    logic [31:0] cmd_ns    = 32'h0;
    logic [31:0] rd_data   = 32'h0;
    logic        sel       = 1'b0;

    assign if1.cmd_valid  = cmd_valid & ~sel;
    assign if3.cmd_valid  = cmd_valid & sel;
    assign if1.cmd_op     = cmd_op;
    assign if3.cmd_op     = cmd_op;
    assign if1.cmd_sec    = cmd_sec;
    assign if3.cmd_sec    = cmd_sec;
    assign if1.cmd_ns     = cmd_ns;
    assign if3.cmd_ns     = cmd_ns;
    assign if1.up_data_rd = rd_data;
    assign if3.up_data_rd = rd_data;

    logic        s_wr, s_rd, s_ready, s_rvld, s_rerr;
    logic [7:0]  s_addr;
    logic [31:0] s_wdat, s_rsec, s_rns;

    always_comb begin
        if (sel) begin
            s_wr = if3.up_wr; s_rd = if3.up_rd; s_ready = if3.cmd_ready;
            s_rvld = if3.rsp_valid; s_rerr = if3.rsp_err; s_addr = if3.up_addr;
            s_wdat = if3.up_data_wr; s_rsec = if3.rsp_sec; s_rns = if3.rsp_ns;
        end else begin
            s_wr = if1.up_wr; s_rd = if1.up_rd; s_ready = if1.cmd_ready;
            s_rvld = if1.rsp_valid; s_rerr = if1.rsp_err; s_addr = if1.up_addr;
            s_wdat = if1.up_data_wr; s_rsec = if1.rsp_sec; s_rns = if1.rsp_ns;
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 8;
    int          lat = 1;
    logic [31:0] rtc_sec = 32'h0;
    logic [31:0] rtc_ns = 32'h0;
    logic        hist_rd [8];
    logic [7:0]  hist_addr [8];
    logic        prev_stb = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [7:0] a);
        if (a == 8'h10) return rtc_sec;
        if (a == 8'h14) return rtc_ns;
        return 32'hBAD0_0000 ^ {24'h0, a};
    endfunction

    // Advance one clock, sample just after the edge, and play the responder:
    // read data is valid only in the cycle RD_LAT after the read strobe, junk otherwise.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        hist_rd[3'(cyc)]   = s_rd;
        hist_addr[3'(cyc)] = s_addr;
        if (hist_rd[3'(cyc - lat)]) rd_data = reg_val(hist_addr[3'(cyc - lat)]);
        else                        rd_data = $urandom;
        check_eq("strobe_overlap", 64'(s_wr & s_rd), 64'(0));
        check_eq("strobe_spacing", 64'(prev_stb & (s_wr | s_rd)), 64'(0));
        prev_stb = s_wr | s_rd;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"},  64'(s_ready), 64'(0));
        check_eq({tag, "_rvld"},   64'(s_rvld),  64'(0));
        check_eq({tag, "_rerr"},   64'(s_rerr),  64'(0));
        check_eq({tag, "_rsec"},   64'(s_rsec),  64'(0));
        check_eq({tag, "_rns"},    64'(s_rns),   64'(0));
        check_eq({tag, "_wr"},     64'(s_wr),    64'(0));
        check_eq({tag, "_rd"},     64'(s_rd),    64'(0));
        check_eq({tag, "_addr"},   64'(s_addr),  64'(0));
        check_eq({tag, "_wdat"},   64'(s_wdat),  64'(0));
    endtask

    // Issue one command and check every cycle up to the response against the model.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] sec, input logic [31:0] ns, input bit hold);
        int          n;
        int          t;
        int          k;
        int          rsp_cyc;
        int          waited;
        logic        e_rd [3];
        logic [7:0]  e_addr [3];
        logic [31:0] e_dat [3];
        int          e_cyc [3];
        logic        exp_wr, exp_rd;
        logic [31:0] exp_sec, exp_ns;

        // Register sequence per opcode, straight from the ha1588 programming model.
        for (int i = 0; i < 3; i++) begin e_rd[i] = 0; e_addr[i] = 0; e_dat[i] = 0; e_cyc[i] = 0; end
        case (op)
            2'd0: begin
                n = 3;
                e_rd[0] = 0; e_addr[0] = 8'h00; e_dat[0] = 32'h1;
                e_rd[1] = 1; e_addr[1] = 8'h10; e_dat[1] = 32'h0;
                e_rd[2] = 1; e_addr[2] = 8'h14; e_dat[2] = 32'h0;
            end
            2'd1: begin
                n = 3;
                e_rd[0] = 0; e_addr[0] = 8'h10; e_dat[0] = sec;
                e_rd[1] = 0; e_addr[1] = 8'h14; e_dat[1] = ns;
                e_rd[2] = 0; e_addr[2] = 8'h00; e_dat[2] = 32'h2;
            end
            2'd2: begin
                n = 2;
                e_rd[0] = 0; e_addr[0] = 8'h18; e_dat[0] = ns;
                e_rd[1] = 0; e_addr[1] = 8'h00; e_dat[1] = 32'h4;
            end
            default: n = 0;
        endcase
        // A write occupies strobe + 1 gap cycle, a read strobe + RD_LAT cycles.
        t = 1;
        for (int i = 0; i < n; i++) begin
            e_cyc[i] = t;
            t += e_rd[i] ? (1 + lat) : 2;
        end
        rsp_cyc = t;
        exp_sec = (op == 2'd0) ? rtc_sec : 32'h0;
        exp_ns  = (op == 2'd0) ? rtc_ns  : 32'h0;

        waited = 0;
        while (!s_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("ready_wait", 64'(s_ready), 64'(1));
        if (!s_ready) return;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sec   = sec;
        cmd_ns    = ns;
        tick();
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_sec   = $urandom;
            cmd_ns    = $urandom;
        end

        for (int c = 1; c <= rsp_cyc; c++) begin
            if (c > 1) tick();
            k = -1;
            for (int i = 0; i < n; i++) if (e_cyc[i] <= c) k = i;
            exp_wr = 1'b0;
            exp_rd = 1'b0;
            if (k >= 0 && e_cyc[k] == c) begin
                exp_wr = !e_rd[k];
                exp_rd = e_rd[k];
            end
            check_eq("up_wr", 64'(s_wr), 64'(exp_wr));
            check_eq("up_rd", 64'(s_rd), 64'(exp_rd));
            if (k >= 0 && c < rsp_cyc) begin
                check_eq("up_addr",    64'(s_addr), 64'(e_addr[k]));
                check_eq("up_data_wr", 64'(s_wdat), 64'(e_dat[k]));
            end
            check_eq("rsp_valid", 64'(s_rvld), 64'(c == rsp_cyc));
            check_eq("busy_ready", 64'(s_ready), 64'(0));
        end
        check_eq("rsp_err", 64'(s_rerr), 64'(op == 2'd3));
        check_eq("rsp_sec", 64'(s_rsec), 64'(exp_sec));
        check_eq("rsp_ns",  64'(s_rns),  64'(exp_ns));

        tick();
        check_eq("ready_after_resp", 64'(s_ready), 64'(1));
        check_eq("rsp_valid_pulse",  64'(s_rvld),  64'(0));
        check_eq("rsp_sec_hold",     64'(s_rsec),  64'(exp_sec));
        check_eq("rsp_ns_hold",      64'(s_rns),   64'(exp_ns));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            hist_rd[i]   = 1'b0;
            hist_addr[i] = 8'h00;
        end

        // Reset values on both instances.
        #2 rst = 1'b0;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            #1;
            check_all_zero(d == 0 ? "rst1" : "rst3");
        end
        sel = 1'b0;
        lat = 1;
        rst = 1'b1;
        #1;
        check_eq("ready_before_edge", 64'(s_ready), 64'(0));
        tick();
        check_eq("ready_first_edge", 64'(s_ready), 64'(1));

        // Directed cases on the RD_LAT=1 instance.
        rtc_sec = 32'h0000_1234;
        rtc_ns  = 32'h3B9A_C9FF;
        run_cmd(2'd0, $urandom, $urandom, 1'b0);
        run_cmd(2'd1, 32'd5, 32'd999_999_999, 1'b0);
        run_cmd(2'd2, $urandom, 32'h0800_0000, 1'b0);
        run_cmd(2'd3, $urandom, $urandom, 1'b0);

        // Random commands with random idle spacing.
        for (int i = 0; i < 16; i++) begin
            rtc_sec = $urandom;
            rtc_ns  = $urandom;
            repeat ($urandom_range(0, 2)) tick();
            run_cmd(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        // RD_LAT=3 instance with cmd_valid held across two back-to-back reads.
        sel = 1'b1;
        lat = 3;
        repeat (4) tick();
        rtc_sec = $urandom;
        rtc_ns  = $urandom;
        run_cmd(2'd0, 32'h0, 32'h0, 1'b1);
        run_cmd(2'd0, 32'h0, 32'h0, 1'b1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rtc_sec = $urandom;
            rtc_ns  = $urandom;
            repeat ($urandom_range(0, 2)) tick();
            run_cmd(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        // Reset in the middle of a SET_TIME.
        sel = 1'b0;
        lat = 1;
        repeat (4) tick();
        check_eq("mid_ready", 64'(s_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_sec   = $urandom;
        cmd_ns    = $urandom;
        tick();
        cmd_valid = 1'b0;
        check_eq("mid_first_strobe", 64'(s_wr), 64'(1));
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (4) begin
            tick();
            check_eq("mid_no_rsp", 64'(s_rvld), 64'(0));
        end
        rst = 1'b1;
        #1;
        check_eq("mid_ready_hold", 64'(s_ready), 64'(0));
        tick();
        check_eq("mid_ready_back", 64'(s_ready), 64'(1));
        rtc_sec = $urandom;
        rtc_ns  = $urandom;
        run_cmd(2'd0, $urandom, $urandom, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
